// File: rtl/cb_shift_seq.sv
// Sequencer for the Z80 CB rotate/shift group (CB/DDCB/FDCB 00-3F) driving an external combinational rotate unit.
// Optional macro DDCB_REG_COPY_EN: indexed forms also copy the result into register cb_op[2:0].
module cb_shift_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cb_op,
  input  logic [1:0]  idx_mode,
  input  logic [7:0]  disp,
  input  logic [15:0] hl,
  input  logic [15:0] ix,
  input  logic [15:0] iy,
  output logic [2:0]  reg_sel,
  input  logic [7:0]  reg_rdata,
  input  logic [7:0]  flags_in,
  output logic [7:0]  rot_data_in,
  output logic [7:0]  rot_op,
  output logic [7:0]  rot_flags,
  input  logic [15:0] rot_data_out,
  input  logic [7:0]  rot_flags_out,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        reg_we,
  output logic [2:0]  reg_wsel,
  output logic [7:0]  reg_wdata,
  output logic        flags_we,
  output logic [7:0]  flags_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, RD, EXEC, WR, FIN} state_t;

  state_t state, state_nx;

  logic [7:0]  op_p0;
  logic [7:0]  flags_p0;
  logic [15:0] addr_p0;
  logic        memf_p0;
  logic [7:0]  opnd_p1;
  logic [7:0]  res_p2;
`ifdef DDCB_REG_COPY_EN
  logic        copy_p0;
`endif

  logic               indexed;
  logic               memf_in;
  logic signed [15:0] disp_ext;
  logic [15:0]        addr_in;
  logic [7:0]         unused_hi;

  function automatic logic [3:0] xlate(input logic [2:0] sel);
    case (sel)
      3'd0:    xlate = 4'h0;
      3'd1:    xlate = 4'h2;
      3'd2:    xlate = 4'h4;
      3'd3:    xlate = 4'h6;
      3'd4:    xlate = 4'h8;
      3'd5:    xlate = 4'h9;
      3'd6:    xlate = 4'hB;
      default: xlate = 4'hA;
    endcase
  endfunction

  // idx_mode 11 is reserved and falls back to the HL form
  assign indexed  = (idx_mode == 2'b01) || (idx_mode == 2'b10);
  assign memf_in  = indexed || (cb_op[2:0] == 3'd6);
  assign disp_ext = 16'(signed'(disp));
  assign addr_in  = (idx_mode == 2'b01) ? ix + disp_ext :
                    (idx_mode == 2'b10) ? iy + disp_ext : hl;

  assign unused_hi = rot_data_out[15:8];
  assign reg_sel   = op_p0[2:0];
  assign rot_op    = {4'h0, xlate(op_p0[5:3])};
  assign rot_flags = flags_p0;
  assign mem_addr  = addr_p0;
  assign busy      = (state != IDLE);

  // Accept / operand capture / result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_p0    <= '0;
      flags_p0 <= '0;
      addr_p0  <= '0;
      memf_p0  <= 1'b0;
      opnd_p1  <= '0;
      res_p2   <= '0;
`ifdef DDCB_REG_COPY_EN
      copy_p0  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        op_p0    <= cb_op;
        flags_p0 <= flags_in;
        addr_p0  <= addr_in;
        memf_p0  <= memf_in;
`ifdef DDCB_REG_COPY_EN
        copy_p0  <= indexed && (cb_op[2:0] != 3'd6);
`endif
      end
      if (state == RD && mem_ready) opnd_p1 <= mem_rdata;
      if (state == EXEC)            res_p2  <= rot_data_out[7:0];
    end
  end

  always_comb begin
    state_nx    = state;
    rot_data_in = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    reg_we      = 1'b0;
    reg_wsel    = '0;
    reg_wdata   = '0;
    flags_we    = 1'b0;
    flags_out   = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cb_op[7:6] != 2'b00) state_nx = FIN;
          else if (memf_in)        state_nx = RD;
          else                     state_nx = EXEC;
        end
      end
      RD: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nx = EXEC;
      end
      EXEC: begin
        rot_data_in = memf_p0 ? opnd_p1 : reg_rdata;
        flags_we    = 1'b1;
        flags_out   = rot_flags_out;
        if (!memf_p0) begin
          reg_we    = 1'b1;
          reg_wsel  = op_p0[2:0];
          reg_wdata = rot_data_out[7:0];
        end
`ifdef DDCB_REG_COPY_EN
        else if (copy_p0) begin
          reg_we    = 1'b1;
          reg_wsel  = op_p0[2:0];
          reg_wdata = rot_data_out[7:0];
        end
`endif
        state_nx = memf_p0 ? WR : FIN;
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_wdata = res_p2;
        if (mem_ready) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cb_shift_seq.sv
// Randomized bench for cb_shift_seq with a behavioural rotate unit, register file and per-cycle expectation queue.
`timescale 1ns/1ps
module tb_cb_shift_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cb_op = '0;
  logic [1:0]  idx_mode = '0;
  logic [7:0]  disp = '0;
  logic [15:0] hl = '0, ix = '0, iy = '0;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_rdata;
  logic [7:0]  flags_in = '0;
  logic [7:0]  rot_data_in, rot_op, rot_flags;
  logic [15:0] rot_data_out;
  logic [7:0]  rot_flags_out;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        reg_we;
  logic [2:0]  reg_wsel;
  logic [7:0]  reg_wdata;
  logic        flags_we;
  logic [7:0]  flags_out;
  logic        busy, done;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] regs [8];
  logic [7:0] opcode_tab [8] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h09, 8'h0B, 8'h0A};

  always #5 clk = ~clk;

  cb_shift_seq dut (
    .clk(clk), .reset(reset), .start(start), .cb_op(cb_op), .idx_mode(idx_mode),
    .disp(disp), .hl(hl), .ix(ix), .iy(iy), .reg_sel(reg_sel), .reg_rdata(reg_rdata),
    .flags_in(flags_in), .rot_data_in(rot_data_in), .rot_op(rot_op), .rot_flags(rot_flags),
    .rot_data_out(rot_data_out), .rot_flags_out(rot_flags_out), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .reg_we(reg_we), .reg_wsel(reg_wsel), .reg_wdata(reg_wdata),
    .flags_we(flags_we), .flags_out(flags_out), .busy(busy), .done(done)
  );

  // Z80 rotate/shift semantics: returns {flags, result}; flags carry S, Z, P/V, C only.
  function automatic logic [15:0] ref_rot(input logic [2:0] k, input logic [7:0] v, input logic cin);
    logic [7:0] r;
    logic c;
    case (k)
      3'd0: begin r = {v[6:0], v[7]}; c = v[7]; end
      3'd1: begin r = {v[0], v[7:1]}; c = v[0]; end
      3'd2: begin r = {v[6:0], cin};  c = v[7]; end
      3'd3: begin r = {cin, v[7:1]};  c = v[0]; end
      3'd4: begin r = {v[6:0], 1'b0}; c = v[7]; end
      3'd5: begin r = {v[7], v[7:1]}; c = v[0]; end
      3'd6: begin r = {v[6:0], 1'b1}; c = v[7]; end
      default: begin r = {1'b0, v[7:1]}; c = v[0]; end
    endcase
    ref_rot = {r[7], (r == 8'h00), 3'b000, ~^r, 1'b0, c, r};
  endfunction

  function automatic logic [15:0] addr_of(input logic [1:0] im, input logic [7:0] d,
                                          input logic [15:0] h, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] off;
    off = {{8{d[7]}}, d};
    if (im == 2'b01)      addr_of = x + off;
    else if (im == 2'b10) addr_of = y + off;
    else                  addr_of = h;
  endfunction

  assign reg_rdata = regs[reg_sel];

  always_comb begin
    logic [15:0] t;
    t = 16'hFFFF;
    for (int i = 0; i < 8; i++)
      if (rot_op == opcode_tab[i]) t = ref_rot(3'(i), rot_data_in, rot_flags[0]);
    rot_flags_out = t[15:8];
    rot_data_out  = {8'hA5, t[7:0]};
  end

  typedef struct packed {
    logic        busy, done, rd, wr, rwe, fwe, ex;
    logic [15:0] addr;
    logic [7:0]  wdata, rwdata, fout, rop, rflags, rdin;
    logic [2:0]  wsel;
  } exp_t;

  exp_t expq[$];

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
    if (got !== want) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] want);
    nvec++;
    cmp(nm, got, want);
  endtask

  // Per-cycle compare, sampled mid-cycle after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      e = (expq.size() > 0) ? expq.pop_front() : idle_exp();
      nvec++;
      cmp("busy", 16'(busy), 16'(e.busy));
      cmp("done", 16'(done), 16'(e.done));
      cmp("mem_rd", 16'(mem_rd), 16'(e.rd));
      cmp("mem_wr", 16'(mem_wr), 16'(e.wr));
      cmp("reg_we", 16'(reg_we), 16'(e.rwe));
      cmp("flags_we", 16'(flags_we), 16'(e.fwe));
      if (e.rd || e.wr) cmp("mem_addr", mem_addr, e.addr);
      if (e.wr) cmp("mem_wdata", 16'(mem_wdata), 16'(e.wdata));
      if (e.rwe) begin
        cmp("reg_wsel", 16'(reg_wsel), 16'(e.wsel));
        cmp("reg_wdata", 16'(reg_wdata), 16'(e.rwdata));
      end
      if (e.fwe) cmp("flags_out", 16'(flags_out), 16'(e.fout));
      if (e.ex) begin
        cmp("rot_op", 16'(rot_op), 16'(e.rop));
        cmp("rot_flags", 16'(rot_flags), 16'(e.rflags));
        cmp("rot_data_in", 16'(rot_data_in), 16'(e.rdin));
      end
    end
  end

  task automatic scramble();
    cb_op    = 8'($urandom);
    idx_mode = 2'($urandom);
    disp     = 8'($urandom);
    hl       = 16'($urandom);
    ix       = 16'($urandom);
    iy       = 16'($urandom);
    flags_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start     = 1'b0;
      mem_ready = 1'($urandom);
      mem_rdata = 8'($urandom);
      scramble();
    end
  endtask

  // Timeline per cycle after start: 1=RD 2=EXEC 3=WR 4=FIN
  task automatic run_op(input logic [7:0] op, input logic [1:0] im, input logic [7:0] d,
                        input logic [15:0] h, input logic [15:0] x, input logic [15:0] y,
                        input logic [7:0] fin, input logic [7:0] mval, input logic [7:0] rval,
                        input int rw, input int ww, output int cycles);
    logic legal, indexed, memf, cpy;
    logic [15:0] addr, rr;
    logic [7:0] opnd;
    int st[$];
    logic rdy[$];
    exp_t e;
    legal   = (op[7:6] == 2'b00);
    indexed = (im == 2'b01) || (im == 2'b10);
    memf    = indexed || (op[2:0] == 3'd6);
`ifdef DDCB_REG_COPY_EN
    cpy = indexed && (op[2:0] != 3'd6);
`else
    cpy = 1'b0;
`endif
    addr = addr_of(im, d, h, x, y);
    opnd = memf ? mval : rval;
    rr   = ref_rot(op[5:3], opnd, fin[0]);
    if (!legal) begin
      st.push_back(4); rdy.push_back(1'($urandom));
    end else begin
      if (memf)
        for (int i = 0; i <= rw; i++) begin st.push_back(1); rdy.push_back(i == rw); end
      st.push_back(2); rdy.push_back(1'($urandom));
      if (memf)
        for (int i = 0; i <= ww; i++) begin st.push_back(3); rdy.push_back(i == ww); end
      st.push_back(4); rdy.push_back(1'($urandom));
    end
    cycles = st.size();
    @(negedge clk);
    regs[op[2:0]] = rval;
    cb_op = op; idx_mode = im; disp = d; hl = h; ix = x; iy = y; flags_in = fin;
    mem_ready = 1'($urandom); mem_rdata = 8'($urandom);
    start = 1'b1;
    foreach (st[k]) begin
      e = idle_exp();
      e.busy = 1'b1;
      case (st[k])
        1: begin e.rd = 1'b1; e.addr = addr; end
        2: begin
          e.ex = 1'b1; e.fwe = 1'b1; e.fout = rr[15:8];
          e.rop = opcode_tab[op[5:3]]; e.rflags = fin; e.rdin = opnd;
          if (!memf || cpy) begin e.rwe = 1'b1; e.wsel = op[2:0]; e.rwdata = rr[7:0]; end
        end
        3: begin e.wr = 1'b1; e.addr = addr; e.wdata = rr[7:0]; end
        default: e.done = 1'b1;
      endcase
      expq.push_back(e);
    end
    foreach (st[k]) begin
      @(negedge clk);
      scramble();
      start     = 1'b1;
      mem_ready = rdy[k];
      mem_rdata = rdy[k] ? mval : 8'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    #3;
    nvec++;
    cmp("rst_busy", 16'(busy), 16'h0);
    cmp("rst_done", 16'(done), 16'h0);
    cmp("rst_mem_rd", 16'(mem_rd), 16'h0);
    cmp("rst_mem_wr", 16'(mem_wr), 16'h0);
    cmp("rst_reg_we", 16'(reg_we), 16'h0);
    cmp("rst_flags_we", 16'(flags_we), 16'h0);
    cmp("rst_rot_op", 16'(rot_op), 16'h0);
    cmp("rst_rot_data_in", 16'(rot_data_in), 16'h0);
    cmp("rst_rot_flags", 16'(rot_flags), 16'h0);
    cmp("rst_mem_addr", mem_addr, 16'h0);
    cmp("rst_flags_out", 16'(flags_out), 16'h0);
    cmp("rst_reg_wsel", 16'(reg_wsel), 16'h0);
    cmp("rst_reg_wdata", 16'(reg_wdata), 16'h0);
    cmp("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2);

    lit("model_rlc_85", ref_rot(3'd0, 8'h85, 1'b0), 16'h010B);
    lit("model_rr_01", ref_rot(3'd3, 8'h01, 1'b1), 16'h8180);
    lit("model_srl_01", ref_rot(3'd7, 8'h01, 1'b0), 16'h4500);
    lit("model_rlc_80", ref_rot(3'd0, 8'h80, 1'b0), 16'h0101);
    lit("model_addr_ix", addr_of(2'b01, 8'h20, 16'h1234, 16'hFFF0, 16'h0), 16'h0010);
    lit("model_addr_iy", addr_of(2'b10, 8'hFE, 16'h1234, 16'h0, 16'h1000), 16'h0FFE);
    lit("model_addr_rsv", addr_of(2'b11, 8'hFE, 16'h1234, 16'h5, 16'h6), 16'h1234);

    run_op(8'h00, 2'b00, 8'h00, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00, 8'h85, 0, 0, cyc);
    lit("rlc_b_done_cycle", 16'(cyc), 16'd2);
    run_op(8'h1E, 2'b00, 8'h00, 16'h4000, 16'h0, 16'h0, 8'h01, 8'h01, 8'h00, 2, 0, cyc);
    lit("rr_hl_done_cycle", 16'(cyc), 16'd6);
    run_op(8'h3E, 2'b01, 8'h20, 16'h0, 16'hFFF0, 16'h0, 8'h00, 8'h01, 8'h00, 0, 0, cyc);
    lit("srl_ix_done_cycle", 16'(cyc), 16'd4);
    run_op(8'h02, 2'b10, 8'hFE, 16'h0, 16'h0, 16'h1000, 8'h00, 8'h80, 8'h33, 0, 1, cyc);
    idle(2);

    // Reset while a read is stalled
    @(negedge clk);
    cb_op = 8'h1E; idx_mode = 2'b00; hl = 16'h2222; mem_ready = 1'b0; start = 1'b1;
    begin
      exp_t e;
      e = idle_exp(); e.busy = 1'b1; e.rd = 1'b1; e.addr = 16'h2222;
      expq.push_back(e);
      expq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    nvec++;
    cmp("rstmid_mem_rd", 16'(mem_rd), 16'h0);
    cmp("rstmid_busy", 16'(busy), 16'h0);
    cmp("rstmid_done", 16'(done), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    run_op(8'h00, 2'b00, 8'h00, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00, 8'h85, 0, 0, cyc);
    run_op(8'h46, 2'b00, 8'h00, 16'h0, 16'h0, 16'h0, 8'hFF, 8'h00, 8'h12, 0, 0, cyc);
    lit("illegal_done_cycle", 16'(cyc), 16'd1);
    idle(2);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] op;
      op = 8'($urandom);
      if ($urandom_range(0, 7) != 0) op[7:6] = 2'b00;
      run_op(op, 2'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), cyc);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cb_shift_seq.md
# cb_shift_seq

Sequencer for the Z80 CB-prefixed rotate/shift group (CB 00–3F, DD CB d 00–3F, FD CB d 00–3F). It sits directly upstream of the combinational rotate/shift unit. It latches the decoded opcode and operand, translates the opcode to the unit's 4-bit operation code, and drives the unit's inputs. It captures the unit's result and flags, then writes them back to the register file, the memory bus and the flag register.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  accepted only in IDLE; latches all operation inputs
- cb_op  in  8  CB opcode byte; [7:6] group, [5:3] operation, [2:0] register
- idx_mode  in  2  00 = HL, 01 = IX+d, 10 = IY+d, 11 = reserved, treated as 00
- disp  in  8  signed displacement d
- hl, ix, iy  in  16 each  pointer values
- reg_sel  out  3  register read select; equals the latched cb_op[2:0]
- reg_rdata  in  8  register read data
- flags_in  in  8  current F register
- rot_data_in, rot_op, rot_flags  out  8 each  drive the rotate unit
- rot_data_out  in  16  rotate unit result; only [7:0] is used
- rot_flags_out  in  8  rotate unit flags
- mem_addr  out  16
- mem_rd, mem_wr  out  1 each
- mem_wdata  out  8
- mem_rdata  in  8
- mem_ready  in  1
- reg_we  out  1
- reg_wsel  out  3
- reg_wdata  out  8
- flags_we  out  1
- flags_out  out  8
- busy  out  1
- done  out  1  single-cycle completion pulse

## Operation
- Operation translation (cb_op[5:3] → rot_op): RLC 000→0x00, RRC 001→0x02, RL 010→0x04, RR 011→0x06, SLA 100→0x08, SRA 101→0x09, SLL 110→0x0B, SRL 111→0x0A. The upper nibble of rot_op is always 0.
- On accept, the block latches cb_op, flags_in and the operand address.
  - Operand address is hl when idx_mode = 00.
  - Otherwise it is (ix or iy) + sign-extended disp, modulo 2^16.
- Memory form: idx_mode ≠ 00, or cb_op[2:0] = 110. Register form: all other cases.
- rot_flags carries the latched flags_in. The carry input for RL/RR comes from this latched value.
- States:
  - IDLE
    - start with cb_op[7:6] = 00, register form → EXEC; memory form → RD.
    - start with cb_op[7:6] ≠ 00 → FIN, with no bus, register or flag activity.
  - RD: mem_rd = 1 and mem_addr is valid. When mem_ready = 1, capture mem_rdata as the operand and go to EXEC.
  - EXEC
    - rot_data_in carries the operand, from reg_rdata in register form or from the captured byte in memory form.
    - flags_we = 1 and flags_out = rot_flags_out.
    - Register form: reg_we = 1, reg_wsel = cb_op[2:0], reg_wdata = rot_data_out[7:0]; next state FIN.
    - Memory form: capture rot_data_out[7:0] as the result; next state WR.
  - WR: mem_wr = 1, mem_wdata = result. When mem_ready = 1, go to FIN.
  - FIN: done = 1; next state IDLE.
- busy = 1 in every state except IDLE.
- start is ignored while busy = 1.

## Timing
- Reset: state IDLE. All outputs are 0, including rot_op, rot_data_in, rot_flags, mem_addr, flags_out and reg_wsel.
  - Reset asserted mid-operation drops mem_rd and mem_wr immediately.
  - No done pulse and no further writes occur after that reset.
- Register form: start is sampled at edge 0; EXEC is cycle 1; done is asserted in cycle 2.
- Memory form with mem_ready = 1 on first request: RD cycle 1, EXEC cycle 2, WR cycle 3, done in cycle 4.
- Each wait cycle (mem_ready = 0) adds one cycle in RD or WR. mem_addr stays stable across RD through WR.
- Illegal group: done is asserted in cycle 1.
- flags_we and reg_we are single-cycle strobes, asserted in EXEC only.
- The rotate unit is purely combinational, so its result is consumed in the same EXEC cycle.

## Configuration
- DDCB_REG_COPY_EN defined: for idx_mode ≠ 00 with cb_op[2:0] ≠ 110, EXEC also asserts reg_we with reg_wsel = cb_op[2:0] and reg_wdata = the result. This is the undocumented Z80 register copy.
- DDCB_REG_COPY_EN undefined: indexed forms never assert reg_we.

## Test plan
- RLC B: cb_op = 0x00, reg_rdata = 0x85, flags_in = 0x00 → in cycle 1, reg_we = 1, reg_wsel = 0, reg_wdata = 0x0B, flags_out = 0x01; done in cycle 2.
- RR (HL): cb_op = 0x1E, hl = 0x4000, flags_in = 0x01, mem_rdata = 0x01, mem_ready delayed 2 cycles → mem_addr = 0x4000, mem_wdata = 0x80, flags_out = 0x81; done in cycle 6.
- SRL (IX+d) with address wrap: idx_mode = 01, ix = 0xFFF0, disp = 0x20, cb_op = 0x3E, mem_rdata = 0x01 → mem_addr = 0x0010, mem_wdata = 0x00, flags_out = 0x45.
- RLC (IY−2) with register copy: idx_mode = 10, iy = 0x1000, disp = 0xFE, cb_op = 0x02, mem_rdata = 0x80 → mem_addr = 0x0FFE, mem_wdata = 0x01. With the macro defined, reg_we = 1, reg_wsel = 2, reg_wdata = 0x01; without it, reg_we stays 0.
- Reset during RD with mem_ready held at 0 → mem_rd = 0 and busy = 0 immediately, no done; a subsequent RLC B completes normally.
- Illegal group: cb_op = 0x46 → done in cycle 1, with no mem_rd, mem_wr, reg_we or flags_we. A start issued while busy is ignored and produces no second done.
